line_assembler: RTL and testbench
=================================

LINE_ASSEMBLER -- requirements
Module: line_assembler

Interface
REQ-001 SHALL have parameter DATA_W, default 8, character width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, maximum characters held per line (DEPTH >= 2).
REQ-003 SHALL have parameter TERM, default 8'd10 (ENTER), the line-terminator code.
REQ-004 SHALL define LEN_W = $clog2(DEPTH+1) internally.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  input character present.
REQ-008 SHALL have port in_data  input  DATA_W  input character code.
REQ-009 SHALL have port in_ready  output  1  block accepts a character this cycle.
REQ-010 SHALL have port out_valid  output  1  output character present.
REQ-011 SHALL have port out_data  output  DATA_W  output character code.
REQ-012 SHALL have port out_last  output  1  marks final character of a line.
REQ-013 SHALL have port out_ready  input  1  downstream accepts output.
REQ-014 SHALL have port line_len  output  LEN_W  stored length of the line being drained.
REQ-015 SHALL have port line_done  output  1  one-cycle pulse when a line completes draining.
REQ-016 SHALL have port overflow  output  1  sticky: current line lost at least one character.

Function
REQ-017 SHALL implement FSM states COLLECT and DRAIN; a transfer occurs when valid and ready are both high on a clock edge.
REQ-018 In COLLECT, in_ready SHALL be 1 and out_valid 0; in DRAIN, in_ready SHALL be 0.
REQ-019 In COLLECT, an accepted non-TERM character SHALL be written at index wr_cnt and wr_cnt incremented, when wr_cnt < DEPTH.
REQ-020 With wr_cnt == DEPTH, an accepted non-TERM character SHALL be discarded and overflow set to 1; in_ready stays 1 (no stall).
REQ-021 An accepted TERM with wr_cnt > 0 SHALL latch line_len = wr_cnt and enter DRAIN on the next cycle; TERM itself is not stored.
REQ-022 An accepted TERM with wr_cnt == 0 SHALL pulse line_done on the next cycle, clear overflow, and remain in COLLECT (empty line, no output beats).
REQ-023 In DRAIN, out_valid SHALL be 1 with out_data = buffer[rd_idx], starting at rd_idx = 0; out_data SHALL hold stable while out_valid && !out_ready.
REQ-024 out_last SHALL be 1 exactly when rd_idx == line_len-1 in DRAIN.
REQ-025 On the out_last transfer the block SHALL return to COLLECT, clear wr_cnt and rd_idx, clear overflow, and pulse line_done for that one cycle after.
REQ-026 Latency: first out beat SHALL be valid one cycle after the TERM transfer; one beat per cycle under continuous out_ready.
REQ-027 line_len SHALL hold its value through DRAIN and until the next TERM latch.

Reset
REQ-028 On reset high at a clock edge, state SHALL become COLLECT; wr_cnt, rd_idx, line_len = 0; out_valid, out_last, line_done, overflow = 0; in_ready = 1 the following cycle.
REQ-029 Reset asserted mid-COLLECT or mid-DRAIN SHALL abandon the partial/pending line with no further output beats; buffer contents need not be cleared.

Configuration
REQ-030 Macro LINE_ASSEMBLER_BACKSPACE_EN SHALL, when defined, make an accepted code 8'd8 in COLLECT decrement wr_cnt if wr_cnt > 0 (no-op at 0), never stored, never setting overflow.
REQ-031 Without LINE_ASSEMBLER_BACKSPACE_EN, code 8'd8 SHALL be treated as an ordinary character.

Verification
REQ-032 Send "abc",10 with out_ready=1 -> beats 'a','b','c' on consecutive cycles, out_last on 'c', line_len=3, one line_done pulse.
REQ-033 Send 10 alone -> no out_valid, line_done pulses once, line_len unchanged at previous value.
REQ-034 DEPTH=4, send "abcdef",10 -> beats "abcd", out_last on 'd', overflow=1 from 'e' until cleared after drain.
REQ-035 Send "hi",10 with out_ready toggling 0/1 each cycle -> 'h','i' each held stable until accepted, in_ready=0 throughout DRAIN.
REQ-036 Send "ab", assert reset one cycle, send "x",10 -> single beat 'x' with out_last, line_len=1.
REQ-037 With LINE_ASSEMBLER_BACKSPACE_EN: send 8,"ab",8,"c",10 -> beats 'a','c', line_len=2; without macro -> line_len=5, beats 8,'a','b',8,'c'.

Source files
------------

// File: rtl/line_assembler.sv
// line_assembler: collects characters into a line buffer until a terminator
// arrives, then drains the stored line as a valid/ready stream.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   in_valid/in_data    - input character stream
//   in_ready            - high while collecting (never stalls on a full buffer)
//   out_valid/out_data  - stored line, one character per accepted beat
//   out_last            - marks the final character of a line
//   out_ready           - downstream accept
//   line_len            - stored length of the line being drained
//   line_done           - one-cycle pulse once a line (possibly empty) completes
//   overflow            - sticky: current line dropped at least one character
//
// Build option: define LINE_ASSEMBLER_BACKSPACE_EN to make code 8 erase the
// previous character while collecting instead of being stored.
module line_assembler #(
   parameter int unsigned        DATA_W = 8,
   parameter int unsigned        DEPTH  = 32,
   parameter logic [DATA_W-1:0]  TERM   = DATA_W'(10)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_last,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   line_len,
   output logic                         line_done,
   output logic                         overflow
);

   localparam int unsigned LEN_W  = $clog2(DEPTH+1);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   typedef enum logic {COLLECT, DRAIN} state_t;

   state_t              state, state_nxt;
   logic [LEN_W-1:0]    wr_cnt, wr_cnt_nxt;
   logic [LEN_W-1:0]    rd_idx, rd_idx_nxt;
   logic [LEN_W-1:0]    line_len_nxt;
   logic                overflow_nxt, line_done_nxt;
   logic                in_ready_nxt, out_valid_nxt, out_last_nxt;
   logic [DATA_W-1:0]   out_data_nxt;
   logic                buf_we;
   logic                in_fire, out_fire, is_term, is_bs;

   logic [DATA_W-1:0]   buffer [DEPTH];

   assign in_fire = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign is_term = (in_data == TERM);

`ifdef LINE_ASSEMBLER_BACKSPACE_EN
   localparam logic [DATA_W-1:0] BS_CODE = DATA_W'(8);
   assign is_bs = (in_data == BS_CODE);
`else
   assign is_bs = 1'b0;
`endif

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= COLLECT;
         wr_cnt    <= '0;
         rd_idx    <= '0;
         line_len  <= '0;
         overflow  <= 1'b0;
         line_done <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         state     <= state_nxt;
         wr_cnt    <= wr_cnt_nxt;
         rd_idx    <= rd_idx_nxt;
         line_len  <= line_len_nxt;
         overflow  <= overflow_nxt;
         line_done <= line_done_nxt;
         in_ready  <= in_ready_nxt;
         out_valid <= out_valid_nxt;
         out_last  <= out_last_nxt;
         out_data  <= out_data_nxt;
      end
   end

   // Line storage; contents survive reset, only the counters are cleared
   always_ff @(posedge clk) begin
      if (buf_we) buffer[ADDR_W'(wr_cnt)] <= in_data;
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state;
      wr_cnt_nxt    = wr_cnt;
      rd_idx_nxt    = rd_idx;
      line_len_nxt  = line_len;
      overflow_nxt  = overflow;
      line_done_nxt = 1'b0;
      in_ready_nxt  = in_ready;
      out_valid_nxt = out_valid;
      out_last_nxt  = out_last;
      out_data_nxt  = out_data;
      buf_we        = 1'b0;

      case (state)
         COLLECT: begin
            if (in_fire) begin
               if (is_term) begin
                  if (wr_cnt != '0) begin
                     // Preload the first beat so out_data is registered
                     state_nxt     = DRAIN;
                     line_len_nxt  = wr_cnt;
                     rd_idx_nxt    = '0;
                     in_ready_nxt  = 1'b0;
                     out_valid_nxt = 1'b1;
                     out_data_nxt  = buffer[ADDR_W'(0)];
                     out_last_nxt  = (wr_cnt == LEN_W'(1));
                  end else begin
                     line_done_nxt = 1'b1;
                     overflow_nxt  = 1'b0;
                  end
               end else if (is_bs) begin
                  if (wr_cnt != '0) wr_cnt_nxt = wr_cnt - LEN_W'(1);
               end else if (wr_cnt < LEN_W'(DEPTH)) begin
                  buf_we     = 1'b1;
                  wr_cnt_nxt = wr_cnt + LEN_W'(1);
               end else begin
                  overflow_nxt = 1'b1;
               end
            end
         end

         DRAIN: begin
            if (out_fire) begin
               if (out_last) begin
                  state_nxt     = COLLECT;
                  wr_cnt_nxt    = '0;
                  rd_idx_nxt    = '0;
                  overflow_nxt  = 1'b0;
                  line_done_nxt = 1'b1;
                  in_ready_nxt  = 1'b1;
                  out_valid_nxt = 1'b0;
                  out_last_nxt  = 1'b0;
               end else begin
                  // Fetch the following character; last when it is index line_len-1
                  rd_idx_nxt   = rd_idx + LEN_W'(1);
                  out_data_nxt = buffer[ADDR_W'(rd_idx + LEN_W'(1))];
                  out_last_nxt = ((rd_idx + LEN_W'(2)) == line_len);
               end
            end
         end

         default: state_nxt = COLLECT;
      endcase
   end

endmodule

// File: tb/tb_line_assembler.sv
// Testbench for line_assembler: two instances (DEPTH=4 and default DEPTH=32)
// driven one at a time, checked every cycle against a queue-based line model.
module tb_line_assembler;

`ifdef LINE_ASSEMBLER_BACKSPACE_EN
   localparam bit BS_EN = 1'b1;
`else
   localparam bit BS_EN = 1'b0;
`endif
   localparam int unsigned DEP_S  = 4;
   localparam int unsigned DEP_B  = 32;
   localparam logic [7:0]  TERM_C = 8'd10;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       in_valid = '0;
   logic [1:0][7:0]  in_data = '0;
   logic [1:0]       out_ready = '0;

   logic       ir_s, ov_s, ol_s, ld_s, of_s;
   logic [7:0] od_s;
   logic [2:0] len_s;
   logic       ir_b, ov_b, ol_b, ld_b, of_b;
   logic [7:0] od_b;
   logic [5:0] len_b;

   logic [1:0]       o_ir, o_ov, o_ol, o_ld, o_of;
   logic [1:0][7:0]  o_od;
   logic [1:0][5:0]  o_len;

   assign o_ir  = {ir_b, ir_s};
   assign o_ov  = {ov_b, ov_s};
   assign o_ol  = {ol_b, ol_s};
   assign o_ld  = {ld_b, ld_s};
   assign o_of  = {of_b, of_s};
   assign o_od  = {od_b, od_s};
   assign o_len = {len_b, 6'(len_s)};

   line_assembler #(.DATA_W(8), .DEPTH(DEP_S), .TERM(TERM_C)) u_small (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(ir_s),
      .out_valid(ov_s), .out_data(od_s), .out_last(ol_s), .out_ready(out_ready[0]),
      .line_len(len_s), .line_done(ld_s), .overflow(of_s)
   );

   line_assembler u_big (
      .clk(clk), .reset(reset),
      .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(ir_b),
      .out_valid(ov_b), .out_data(od_b), .out_last(ol_b), .out_ready(out_ready[1]),
      .line_len(len_b), .line_done(ld_b), .overflow(of_b)
   );

   always #5 clk = ~clk;

   // Scoreboard state
   int              n_tests = 0;
   int              n_fail = 0;
   int              act = 1;
   logic [7:0]      cur_q[$];
   logic [7:0]      drn_q[$];
   bit              draining = 1'b0;
   bit              done_due = 1'b0;
   int              beat = 0;
   logic [1:0]      exp_ovf = '0;
   logic [1:0][5:0] exp_len = '0;
   bit              chk_en = 1'b0;
   int              rdy_mode = 0;
   int              cyc = 0;

   // Observed-beat log for literal checks
   logic [63:0]     log_v = '0;
   int              log_n = 0;
   int              log_last_n = 0;
   int              done_cnt = 0;
   int              first_cyc = 0;
   int              last_cyc = 0;

   function automatic int dep(input int i);
      return (i == 0) ? int'(DEP_S) : int'(DEP_B);
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 2'b11;
         1:       out_ready = ~out_ready;
         default: out_ready = 2'($urandom);
      endcase
   end

   // Per-cycle compare of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("overflow[%0d]", i), 64'(o_of[i]), 64'(exp_ovf[i]));
            chk($sformatf("line_len[%0d]", i), 64'(o_len[i]), 64'(exp_len[i]));
            if (o_ld[i]) done_cnt++;
            if (i == act && draining) begin
               chk($sformatf("in_ready_drain[%0d]", i), 64'(o_ir[i]), 64'd0);
               chk($sformatf("out_valid[%0d]", i), 64'(o_ov[i]), 64'd1);
               chk($sformatf("out_data[%0d]", i), 64'(o_od[i]), 64'(drn_q[beat]));
               chk($sformatf("out_last[%0d]", i), 64'(o_ol[i]),
                   64'(beat == drn_q.size() - 1));
               chk($sformatf("line_done_drain[%0d]", i), 64'(o_ld[i]), 64'd0);
               if (out_ready[i]) begin
                  log_v = {log_v[55:0], o_od[i]};
                  log_n++;
                  if (o_ol[i]) log_last_n++;
                  if (beat == 0) first_cyc = cyc;
                  last_cyc = cyc;
                  beat++;
                  if (beat == drn_q.size()) begin
                     draining   = 1'b0;
                     done_due   = 1'b1;
                     exp_ovf[i] = 1'b0;
                  end
               end
            end else begin
               chk($sformatf("in_ready[%0d]", i), 64'(o_ir[i]), 64'd1);
               chk($sformatf("out_valid_idle[%0d]", i), 64'(o_ov[i]), 64'd0);
               chk($sformatf("line_done[%0d]", i), 64'(o_ld[i]),
                   64'(i == act && done_due));
               if (i == act) done_due = 1'b0;
            end
         end
      end
   end

   task automatic model_reset();
      cur_q.delete();
      drn_q.delete();
      draining = 1'b0;
      done_due = 1'b0;
      beat     = 0;
      exp_ovf  = '0;
      exp_len  = '0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = '0;
      @(posedge clk);
      model_reset();
      #1 reset = 1'b0;
   endtask

   task automatic clr_log();
      log_v = '0; log_n = 0; log_last_n = 0; done_cnt = 0;
   endtask

   // Present one character for one edge; the instance is collecting
   task automatic send_char(input int i, input logic [7:0] c);
      in_valid[i] = 1'b1;
      in_data[i]  = c;
      @(posedge clk);
      if (c == TERM_C) begin
         if (cur_q.size() == 0) begin
            done_due   = 1'b1;
            exp_ovf[i] = 1'b0;
         end else begin
            drn_q      = cur_q;
            beat       = 0;
            draining   = 1'b1;
            exp_len[i] = 6'(cur_q.size());
         end
         cur_q.delete();
      end else if (BS_EN && c == 8'd8) begin
         if (cur_q.size() > 0) void'(cur_q.pop_back());
      end else if (cur_q.size() < dep(i)) begin
         cur_q.push_back(c);
      end else begin
         exp_ovf[i] = 1'b1;
      end
      #1 in_valid[i] = 1'b0;
   endtask

   task automatic send_str(input int i, input string s);
      for (int k = 0; k < s.len(); k++) send_char(i, s[k]);
   endtask

   // Wait out the drain and done pulse, offering junk input that must be ignored
   task automatic wait_line(input int i);
      int t = 0;
      while ((draining || done_due) && t < 500) begin
         if (draining) begin
            in_valid[i] = 1'($urandom_range(0, 1));
            in_data[i]  = 8'($urandom);
         end else begin
            in_valid[i] = 1'b0;
         end
         @(posedge clk);
         #1 t++;
      end
      in_valid[i] = 1'b0;
      if (t >= 500) chk("drain_timeout", 64'd1, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      model_reset();
      #1 reset = 1'b0;
      chk_en = 1'b1;

      // Reset values
      chk("rst_in_ready", 64'(o_ir), 64'h3);
      chk("rst_out_valid", 64'(o_ov), 64'h0);
      chk("rst_line_len", 64'(o_len), 64'h0);
      chk("rst_overflow", 64'(o_of), 64'h0);
      chk("rst_line_done", 64'(o_ld), 64'h0);

      // "abc" on the default instance, continuous out_ready
      act = 1; rdy_mode = 0;
      @(posedge clk); #1;
      clr_log();
      send_str(1, "abc");
      send_char(1, TERM_C);
      wait_line(1);
      chk("abc_beats", log_v, 64'h616263);
      chk("abc_last_cnt", 64'(log_last_n), 64'd1);
      chk("abc_line_len", 64'(o_len[1]), 64'd3);
      chk("abc_done_cnt", 64'(done_cnt), 64'd1);
      chk("abc_consecutive", 64'(last_cyc - first_cyc), 64'd2);

      // Empty line: no beats, one done pulse, line_len kept
      clr_log();
      send_char(1, TERM_C);
      wait_line(1);
      chk("empty_beats", 64'(log_n), 64'd0);
      chk("empty_done_cnt", 64'(done_cnt), 64'd1);
      chk("empty_line_len", 64'(o_len[1]), 64'd3);

      // Overflow on the DEPTH=4 instance
      act = 0;
      clr_log();
      send_str(0, "abcd");
      chk("full_no_ovf", 64'(o_of[0]), 64'd0);
      send_char(0, "e");
      chk("ovf_after_e", 64'(o_of[0]), 64'd1);
      send_char(0, "f");
      send_char(0, TERM_C);
      wait_line(0);
      chk("ovf_beats", log_v, 64'h61626364);
      chk("ovf_last_cnt", 64'(log_last_n), 64'd1);
      chk("ovf_line_len", 64'(o_len[0]), 64'd4);
      chk("ovf_cleared", 64'(o_of[0]), 64'd0);

      // Toggling out_ready
      act = 1; rdy_mode = 1;
      clr_log();
      send_str(1, "hi");
      send_char(1, TERM_C);
      wait_line(1);
      chk("hi_beats", log_v, 64'h6869);
      chk("hi_line_len", 64'(o_len[1]), 64'd2);

      // Reset abandons a partial line
      rdy_mode = 0;
      clr_log();
      send_str(1, "ab");
      do_reset();
      send_str(1, "x");
      send_char(1, TERM_C);
      wait_line(1);
      chk("rst_line_beats", log_v, 64'h78);
      chk("rst_line_last", 64'(log_last_n), 64'd1);
      chk("rst_line_len", 64'(o_len[1]), 64'd1);

      // Reset in the middle of a drain
      rdy_mode = 2;
      send_str(1, "pqrs");
      send_char(1, TERM_C);
      @(posedge clk); #1;
      do_reset();
      chk("rst_drain_valid", 64'(o_ov[1]), 64'd0);
      chk("rst_drain_len", 64'(o_len[1]), 64'd0);

      // Backspace code
      rdy_mode = 0;
      clr_log();
      send_str(1, "\010ab\010c");
      send_char(1, TERM_C);
      wait_line(1);
      if (BS_EN) begin
         chk("bs_beats", log_v, 64'h6163);
         chk("bs_line_len", 64'(o_len[1]), 64'd2);
      end else begin
         chk("bs_beats", log_v, 64'h0861620863);
         chk("bs_line_len", 64'(o_len[1]), 64'd5);
      end

      // Randomized lines on both instances
      for (int inst = 0; inst < 2; inst++) begin
         act = inst;
         for (int ln = 0; ln < 40; ln++) begin
            int n;
            rdy_mode = int'($urandom_range(0, 2));
            n = int'($urandom_range(0, dep(inst) + 3));
            for (int k = 0; k < n; k++) begin
               logic [7:0] c;
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk); #1;
               end
               c = ($urandom_range(0, 7) == 0) ? 8'd8 : 8'($urandom_range(32, 126));
               send_char(inst, c);
            end
            send_char(inst, TERM_C);
            wait_line(inst);
         end
      end

      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
